// File: rtl/uart_pixel_loader_pkg.sv
// Shared definitions for the UART pixel loader and the WS2812 serialiser:
// parser state encodings, frame constants and GRB pixel word layout.
package uart_pixel_loader_pkg;

  localparam int         PIX_W            = 24;
  localparam int         G_OFS            = 16;
  localparam int         R_OFS            = 8;
  localparam int         B_OFS            = 0;
  localparam int         DEF_MAX_PIXELS   = 64;
  localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
  localparam int         DEF_TIMEOUT_CLKS = 52080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_GRN,
    ST_RED,
    ST_BLU,
    ST_CSUM
  } state_e;

  function automatic logic [PIX_W-1:0] pack_grb(input logic [7:0] g,
                                                input logic [7:0] r,
                                                input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/uart_pixel_loader_pixel_buffer.sv
// Pixel buffer: one write port, one registered read port (read-before-write),
// out-of-range read addresses return zero.
module pixel_buffer
  import uart_pixel_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_MAX_PIXELS,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rd_q;

  // NOTE: the memory array deliberately has no reset so it maps onto block RAM;
  // only the output register is cleared.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                         rd_q <= '0;
    else if ({1'b0, i_rd_addr} < DEPTH_W) rd_q <= mem_q[i_rd_addr];
    else                                 rd_q <= '0;
  end

  assign o_rd_data = rd_q;

endmodule

// File: rtl/uart_pixel_loader.sv
// Parses SYNC/LEN/{G,R,B}xLEN/CSUM frames from the UART byte stream into the
// pixel buffer; reports committed frames and rejected/aborted ones.
module uart_pixel_loader
  import uart_pixel_loader_pkg::*;
#(
  parameter int         MAX_PIXELS   = DEF_MAX_PIXELS,
  parameter int         ADDR_W       = 6,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              i_drv_busy,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data,
  output logic              o_frame_valid,
  output logic [7:0]        o_frame_len,
  output logic              o_err
);

  localparam logic [7:0]  MAX_LEN = 8'(MAX_PIXELS);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);

  state_e      state_q;
  logic [7:0]  len_q;
  logic [7:0]  csum_q;
  logic [7:0]  pix_idx_q;
  logic [7:0]  g_q;
  logic [7:0]  r_q;
  logic [31:0] idle_cnt_q;
  logic        frame_valid_q;
  logic        err_q;
  logic [7:0]  frame_len_q;

  logic             wr_en;
  logic [PIX_W-1:0] wr_data;

  // The blue byte completes a pixel and is written in the cycle it arrives.
  assign wr_en   = i_rx_valid && (state_q == ST_BLU);
  assign wr_data = pack_grb(g_q, r_q, i_rx_byte);

  pixel_buffer #(
    .DEPTH (MAX_PIXELS),
    .ADDR_W(ADDR_W)
  ) u_pixel_buffer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_en  (wr_en),
    .i_wr_addr(pix_idx_q[ADDR_W-1:0]),
    .i_wr_data(wr_data),
    .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data)
  );

  // NOTE: non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      csum_q        <= '0;
      pix_idx_q     <= '0;
      g_q           <= '0;
      r_q           <= '0;
      idle_cnt_q    <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      frame_len_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;

      if (i_rx_valid || state_q == ST_IDLE) idle_cnt_q <= '0;
      else                                  idle_cnt_q <= idle_cnt_q + 32'd1;

      if (i_rx_valid) begin
        unique case (state_q)
          ST_IDLE: begin
            if (i_rx_byte == SYNC_BYTE) begin
              if (i_drv_busy) err_q   <= 1'b1;
              else            state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_rx_byte == 8'd0 || i_rx_byte > MAX_LEN) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              len_q     <= i_rx_byte;
              csum_q    <= i_rx_byte;
              pix_idx_q <= '0;
              state_q   <= ST_GRN;
            end
          end
          ST_GRN: begin
            g_q     <= i_rx_byte;
            csum_q  <= csum_q ^ i_rx_byte;
            state_q <= ST_RED;
          end
          ST_RED: begin
            r_q     <= i_rx_byte;
            csum_q  <= csum_q ^ i_rx_byte;
            state_q <= ST_BLU;
          end
          ST_BLU: begin
            csum_q <= csum_q ^ i_rx_byte;
            if (pix_idx_q == len_q - 8'd1) begin
              state_q <= ST_CSUM;
            end else begin
              pix_idx_q <= pix_idx_q + 8'd1;
              state_q   <= ST_GRN;
            end
          end
          ST_CSUM: begin
            if (i_rx_byte == csum_q) begin
              frame_valid_q <= 1'b1;
              frame_len_q   <= len_q;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE && idle_cnt_q == TO_LAST) begin
        // Link went quiet mid-frame: drop the partial frame.
        err_q   <= 1'b1;
        state_q <= ST_IDLE;
      end
    end
  end

  assign o_frame_valid = frame_valid_q;
  assign o_frame_len   = frame_len_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed bench for uart_pixel_loader: table of whole frames plus hand-written
// sequences for max length, read-before-write, timeout and reset corners.
module tb_uart_pixel_loader;

  localparam int MAXP = 60;
  localparam int AW   = 6;
  localparam int TO   = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic          drv_busy = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [23:0]   rd_data;
  logic          frame_valid;
  logic [7:0]    frame_len;
  logic          err;

  uart_pixel_loader #(
    .MAX_PIXELS  (MAXP),
    .ADDR_W      (AW),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_byte    (rx_byte),
    .i_rx_valid   (rx_valid),
    .i_drv_busy   (drv_busy),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_frame_valid(frame_valid),
    .o_frame_len  (frame_len),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid)         fv_cnt   <= fv_cnt + 1;
    if (err)                 err_cnt  <= err_cnt + 1;
    if (frame_valid && err)  both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [23:0] exp);
    rd_addr = a;
    @(negedge clk);
    check(name, {8'h0, rd_data}, {8'h0, exp});
  endtask

  typedef struct packed {
    logic [95:0]   data;
    logic [3:0]    n;
    logic          busy;
    logic          exp_fv;
    logic          exp_err;
    logic [7:0]    exp_len;
    logic [AW-1:0] rd_addr;
    logic [23:0]   exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int fv0, e0;
    logic [7:0] cs, g, r, b;

    vecs[0] = '{96'hA5021020_30405060_72000000, 4'd9, 1'b0, 1'b1, 1'b0, 8'h02, 6'd0, 24'h102030};
    vecs[1] = '{96'hA5021020_30405060_00000000, 4'd9, 1'b0, 1'b0, 1'b1, 8'h02, 6'd1, 24'h405060};
    vecs[2] = '{96'hA5000000_00000000_00000000, 4'd2, 1'b0, 1'b0, 1'b1, 8'h02, 6'd1, 24'h405060};
    vecs[3] = '{96'hA53D0000_00000000_00000000, 4'd2, 1'b0, 1'b0, 1'b1, 8'h02, 6'd0, 24'h102030};
    vecs[4] = '{96'hA501AABB_CCDC0000_00000000, 4'd6, 1'b0, 1'b1, 1'b0, 8'h01, 6'd0, 24'hAABBCC};
    vecs[5] = '{96'hA5011234_56770000_00000000, 4'd6, 1'b1, 1'b0, 1'b1, 8'h01, 6'd0, 24'hAABBCC};
    vecs[6] = '{96'hA501A5A5_A5A40000_00000000, 4'd6, 1'b0, 1'b1, 1'b0, 8'h01, 6'd0, 24'hA5A5A5};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_frame_len", {24'h0, frame_len}, 32'h0);
    check("rst_rd_data", {8'h0, rd_data}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table of whole frames
    for (int v = 0; v < 7; v++) begin
      fv0 = fv_cnt;
      e0  = err_cnt;
      drv_busy = vecs[v].busy;
      for (int i = 0; i < int'(vecs[v].n); i++) send_byte(vecs[v].data[95-8*i -: 8]);
      repeat (3) @(negedge clk);
      drv_busy = 1'b0;
      check($sformatf("vec%0d_fv", v), 32'(fv_cnt - fv0), {31'h0, vecs[v].exp_fv});
      check($sformatf("vec%0d_err", v), 32'(err_cnt - e0), {31'h0, vecs[v].exp_err});
      check($sformatf("vec%0d_len", v), {24'h0, frame_len}, {24'h0, vecs[v].exp_len});
      read_check($sformatf("vec%0d_rd", v), vecs[v].rd_addr, vecs[v].exp_rd);
    end

    // Maximum-length frame
    fv0 = fv_cnt;
    e0  = err_cnt;
    cs  = 8'(MAXP);
    send_byte(8'hA5);
    send_byte(8'(MAXP));
    for (int i = 0; i < MAXP; i++) begin
      g = 8'(i);
      r = 8'(i + 64);
      b = ~8'(i);
      cs = cs ^ g ^ r ^ b;
      send_byte(g);
      send_byte(r);
      send_byte(b);
    end
    send_byte(cs);
    repeat (3) @(negedge clk);
    check("max_fv", 32'(fv_cnt - fv0), 32'd1);
    check("max_err", 32'(err_cnt - e0), 32'd0);
    check("max_len", {24'h0, frame_len}, 32'd60);
    read_check("max_rd59", 6'd59, 24'h3B7BC4);
    read_check("rd_oob60", 6'd60, 24'h0);
    read_check("rd_oob63", 6'd63, 24'h0);

    // Same-cycle write and read of address 0 returns the old word first
    rd_addr = 6'd0;
    fv0 = fv_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    check("rbw_old", {8'h0, rd_data}, 32'h0040FF);
    @(negedge clk);
    check("rbw_new", {8'h0, rd_data}, 32'h778899);
    send_byte(8'h67);
    repeat (2) @(negedge clk);
    check("rbw_fv", 32'(fv_cnt - fv0), 32'd1);

    // Timeout abort after a partial pixel
    fv0 = fv_cnt;
    e0  = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TO - 1) @(negedge clk);
    #1;
    check("to_early_err", 32'(err_cnt - e0), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("to_err_once", 32'(err_cnt - e0), 32'd1);
    check("to_no_fv", 32'(fv_cnt - fv0), 32'd0);
    fv0 = fv_cnt;
    for (int i = 0; i < 6; i++) send_byte(vecs[4].data[95-8*i -: 8]);
    repeat (3) @(negedge clk);
    check("to_recover_fv", 32'(fv_cnt - fv0), 32'd1);

    // Byte arriving on the timeout cycle wins
    fv0 = fv_cnt;
    e0  = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h01);
    repeat (3) @(negedge clk);
    check("race_err", 32'(err_cnt - e0), 32'd0);
    check("race_fv", 32'(fv_cnt - fv0), 32'd1);
    read_check("race_rd", 6'd0, 24'h112233);

    // Reset in the middle of the payload
    read_check("pre_rst_rd1", 6'd1, 24'h0141FE);
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    rst = 1'b1;
    #1;
    check("mid_rst_len", {24'h0, frame_len}, 32'h0);
    check("mid_rst_rd", {8'h0, rd_data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fv0 = fv_cnt;
    for (int i = 0; i < 6; i++) send_byte(vecs[4].data[95-8*i -: 8]);
    repeat (3) @(negedge clk);
    check("post_rst_fv", 32'(fv_cnt - fv0), 32'd1);
    check("post_rst_len", {24'h0, frame_len}, 32'h1);
    check("post_rst_no_err", 32'(err_cnt - e0), 32'd0);
    read_check("post_rst_rd1", 6'd1, 24'h0141FE);

    check("fv_err_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
